// File: rtl/branch_predictor_btb_if.sv
// Bundles the fetch-lookup, resolution-update and redirect signals of the BTB.
//   master : fetch/resolution side (drives pc_f and the update_* fields)
//   slave  : predictor (returns the prediction, the redirect pulse and the mispredict count)
interface branch_predictor_btb_if;
    logic [31:0] pc_f;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        pred_taken_in;
    logic [31:0] pred_target_in;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] mispred_count;

    modport master (
        output pc_f, update_valid, update_pc, branch_taken, branch_addr,
               pred_taken_in, pred_target_in,
        input  predict_taken, predict_target, mispredict, redirect_pc, mispred_count
    );

    modport slave (
        input  pc_f, update_valid, update_pc, branch_taken, branch_addr,
               pred_taken_in, pred_target_in,
        output predict_taken, predict_target, mispredict, redirect_pc, mispred_count
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
//   CLK, nRST : clock and asynchronous active-low reset
//   bus       : slave side of branch_predictor_btb_if
//     pc_f -> predict_taken/predict_target   (combinational lookup, no bypass)
//     update_* / branch_* / pred_*_in         (training and mispredict detection)
//     mispredict/redirect_pc/mispred_count    (registered redirect and statistics)
module branch_predictor_btb #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    branch_predictor_btb_if.slave  bus
);
    localparam int TAG_W = 32 - IDX_W - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        sat_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        sat_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] f_idx_s, u_idx_s;
    logic [TAG_W-1:0] f_tag_s, u_tag_s;
    logic             f_hit_s, u_hit_s, mis_s;
    logic             unused_s;

    assign f_idx_s = bus.pc_f[IDX_W+1:2];
    assign f_tag_s = bus.pc_f[31:IDX_W+2];
    assign u_idx_s = bus.update_pc[IDX_W+1:2];
    assign u_tag_s = bus.update_pc[31:IDX_W+2];
    // Byte-offset bits are always zero for word-aligned PCs.
    assign unused_s = ^{bus.pc_f[1:0], bus.update_pc[1:0]};

    // Fetch-side lookup reads only registered state, so a same-cycle update is not visible.
    always_comb begin
        f_hit_s            = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
        bus.predict_taken  = f_hit_s && ctr_q[f_idx_s][1];
        if (f_hit_s && ctr_q[f_idx_s][1]) begin
            bus.predict_target = target_q[f_idx_s];
        end else begin
            bus.predict_target = 32'h0000_0000;
        end
    end

    // Table training from the resolved branch.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        u_hit_s  = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
        if (bus.update_valid) begin
            if (u_hit_s) begin
                if (bus.branch_taken) begin
                    ctr_d[u_idx_s]    = sat_inc(ctr_q[u_idx_s]);
                    target_d[u_idx_s] = bus.branch_addr;
                end else begin
                    ctr_d[u_idx_s]    = sat_dec(ctr_q[u_idx_s]);
                end
            end else if (bus.branch_taken) begin
                // Allocation replaces whatever aliased entry lived at this index.
                valid_d[u_idx_s]  = 1'b1;
                tag_d[u_idx_s]    = u_tag_s;
                target_d[u_idx_s] = bus.branch_addr;
                ctr_d[u_idx_s]    = 2'b10;
            end else begin
                valid_d[u_idx_s]  = valid_q[u_idx_s];
            end
        end else begin
            valid_d[u_idx_s] = valid_q[u_idx_s];
        end
    end

    // Mispredict detection, redirect target and saturating statistics counter.
    always_comb begin
        mis_s = (bus.branch_taken != bus.pred_taken_in) ||
                (bus.branch_taken && bus.pred_taken_in && (bus.branch_addr != bus.pred_target_in));
        mispredict_d    = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        mispred_count_d = mispred_count_q;
        if (bus.update_valid && mis_s) begin
            mispredict_d  = 1'b1;
            // Fall-through wraps modulo 2^32.
            redirect_pc_d = bus.branch_taken ? bus.branch_addr : (bus.update_pc + 32'd4);
            if (mispred_count_q != 32'hFFFF_FFFF) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end else begin
                mispred_count_d = mispred_count_q;
            end
        end else begin
            mispredict_d = 1'b0;
        end
    end

    // State registers; reset discards any update presented in the same cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= 32'h0000_0000;
                ctr_q[i]    <= 2'b01;
            end
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= 32'h0000_0000;
            mispred_count_q <= 32'h0000_0000;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign bus.mispredict    = mispredict_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios followed by
// randomized traffic, compared against a behavioural table model.
module tb_branch_predictor_btb;
    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    branch_predictor_btb_if bus ();

    branch_predictor_btb dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: 16 entries, counter kept as an integer 0..3.
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    logic        m_mis;
    logic [31:0] m_redirect;
    logic [31:0] m_count;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 1;
        end
        m_mis      = 1'b0;
        m_redirect = 32'h0;
        m_count    = 32'h0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
        int unsigned idx;
        idx   = (pc / 4) % 16;
        taken = m_valid[idx] && (m_tag[idx] == pc / 64) && (m_ctr[idx] >= 2);
        tgt   = taken ? m_target[idx] : 32'h0;
    endtask

    task automatic model_update(input logic [31:0] upc, input logic bt, input logic [31:0] ba,
                                input logic pti, input logic [31:0] ptt);
        int unsigned idx;
        bit          hit;
        idx = (upc / 4) % 16;
        hit = m_valid[idx] && (m_tag[idx] == upc / 64);
        if (hit && bt) begin
            m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            m_target[idx] = ba;
        end else if (hit) begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end else if (bt) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = upc / 64;
            m_target[idx] = ba;
            m_ctr[idx]    = 2;
        end
        m_mis = (bt != pti) || (bt && (ba != ptt));
        if (m_mis) begin
            m_redirect = bt ? ba : upc + 32'd4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: present inputs at negedge, check lookup, clock, check registered outputs.
    task automatic step(input logic [31:0] pcf, input logic uv, input logic [31:0] upc,
                        input logic bt, input logic [31:0] ba, input logic pti, input logic [31:0] ptt);
        logic        et;
        logic [31:0] etg;
        bus.pc_f           = pcf;
        bus.update_valid   = uv;
        bus.update_pc      = upc;
        bus.branch_taken   = bt;
        bus.branch_addr    = ba;
        bus.pred_taken_in  = pti;
        bus.pred_target_in = ptt;
        #1;
        model_predict(pcf, et, etg);
        check("predict_taken", {31'h0, bus.predict_taken}, {31'h0, et});
        check("predict_target", bus.predict_target, etg);
        @(posedge clk);
        if (uv) model_update(upc, bt, ba, pti, ptt);
        else    m_mis = 1'b0;
        #1;
        check("mispredict", {31'h0, bus.mispredict}, {31'h0, m_mis});
        check("redirect_pc", bus.redirect_pc, m_redirect);
        check("mispred_count", bus.mispred_count, m_count);
        @(negedge clk);
    endtask

    initial begin
        logic        et;
        logic [31:0] etg;
        logic [31:0] upc;
        logic [31:0] pcf;
        logic [31:0] ba;
        logic        bt;
        logic        pti;
        logic [31:0] ptt;
        checks = 0;
        errors = 0;
        nrst   = 1'b0;
        bus.pc_f = 32'h100; bus.update_valid = 1'b0; bus.update_pc = 32'h0;
        bus.branch_taken = 1'b0; bus.branch_addr = 32'h0;
        bus.pred_taken_in = 1'b0; bus.pred_target_in = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        // 1: reset state
        check("rst_predict_taken", {31'h0, bus.predict_taken}, 32'h0);
        check("rst_predict_target", bus.predict_target, 32'h0);
        check("rst_mispredict", {31'h0, bus.mispredict}, 32'h0);
        check("rst_mispred_count", bus.mispred_count, 32'h0);
        nrst = 1'b1;
        @(negedge clk);
        // 2: allocate 0x100 -> 0x200 with a not-taken prediction
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        check("t2_redirect", bus.redirect_pc, 32'h200);
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // 3: saturate, then two not-taken mispredicts redirecting to fall-through
        repeat (3) step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        repeat (2) step(32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        check("t3_redirect", bus.redirect_pc, 32'h104);
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // 4: wrong predicted target
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        // 5: alias replacement at index 0, same-cycle lookup sees old contents
        step(32'h140, 1'b1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h0);
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t5_alias_target", bus.predict_target, 32'h500);
        // fall-through wrap at the top of the address space
        step(32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        check("wrap_redirect", bus.redirect_pc, 32'h0);
        // randomized traffic over a small PC pool so aliasing is frequent
        for (int n = 0; n < 400; n++) begin
            upc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom_range(0, 47) << 2);
            pcf = ($urandom_range(0, 1) == 0) ? upc : ($urandom_range(0, 47) << 2);
            bt  = 1'($urandom_range(0, 1));
            ba  = 32'h1000 + ($urandom_range(0, 3) << 4);
            if ($urandom_range(0, 3) != 0) begin
                model_predict(upc, pti, ptt);
            end else begin
                pti = 1'($urandom_range(0, 1));
                ptt = 32'h1000 + ($urandom_range(0, 3) << 4);
            end
            step(pcf, 1'($urandom_range(0, 4) != 0), upc, bt, ba, pti, ptt);
        end
        // 6: reset mid-stream with an update pending
        step(32'h140, 1'b1, 32'h140, 1'b0, 32'h0, 1'b1, 32'h500);
        bus.pc_f = 32'h100; bus.update_valid = 1'b1; bus.update_pc = 32'h100;
        bus.branch_taken = 1'b1; bus.branch_addr = 32'h700; bus.pred_taken_in = 1'b0;
        nrst = 1'b0;
        #1;
        model_reset();
        check("midrst_mispredict", {31'h0, bus.mispredict}, 32'h0);
        check("midrst_redirect", bus.redirect_pc, 32'h0);
        check("midrst_count", bus.mispred_count, 32'h0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        bus.update_valid = 1'b0;
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_predict(32'h140, et, etg);
        step(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // counter saturation from a preloaded maximum
        force dut.mispred_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_count_q;
        m_count = 32'hFFFF_FFFF;
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        check("sat_count", bus.mispred_count, 32'hFFFF_FFFF);
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
